// File: rtl/signal_bundle_arbiter_if.sv
// Bundle of per-channel request signals and the single FIFO output port
// of signal_bundle_arbiter. Widths follow the arbiter parameters.
interface signal_bundle_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        in_ack;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic [LVL_W-1:0]         level;

  // Environment side: sources and the downstream sink.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, in_ack, out_valid, out_data, out_ch, level
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, in_ack, out_valid, out_data, out_ch, level
  );
endinterface

// File: rtl/signal_bundle_arbiter.sv
// Round-robin arbiter merging NUM_CH valid/ready sources into one
// DEPTH-entry FIFO. Each entry carries the payload and its source channel.
// The FIFO head is always registered, so nothing passes combinationally
// from input to output.
module signal_bundle_arbiter #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input logic                   clk,
  input logic                   rst,
  signal_bundle_arbiter_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CH_W-1:0]   rr_ptr;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [CH_W-1:0]   mem_ch   [DEPTH];

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gnt_idx, rr_next;
  logic              found, full, push, pop;
  int                best_d, d;

  // Unpack the flat payload bus into one word per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign ch_data[i]    = bus.in_data[i*DATA_W +: DATA_W];
    assign bus.in_ack[i] = bus.in_valid[i] & grant[i];
  end

  assign full = (level_q == LVL_W'(DEPTH));

  // Pick the valid channel closest to rr_ptr in wrapping search order.
  // A full FIFO grants nobody, even if the head pops this cycle.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    best_d  = NUM_CH;
    d       = 0;
    if (!full) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d = i - int'(rr_ptr);
        if (d < 0) d = d + NUM_CH;
        if (bus.in_valid[i] && d < best_d) begin
          best_d  = d;
          gnt_idx = CH_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

  assign grant        = found ? (NUM_CH'(1) << gnt_idx) : '0;
  assign bus.in_ready = grant;
  assign push         = found;
  assign rr_next      = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_ch    = mem_ch[rd_ptr];
  assign bus.level     = level_q;
  assign pop           = bus.out_valid & bus.out_ready;

  // Pointer, occupancy and round-robin state; reset drops all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= rr_next;
      end
      if (pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is unreset; a write during reset is harmless but suppressed.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr] <= ch_data[gnt_idx];
      mem_ch[wr_ptr]   <= gnt_idx;
    end
  end
endmodule
